// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among NREQ requesters,
// granting bursts of up to MAX_BURST words and throttling on full/almost_full.
module fifo_wr_arbiter #(
  parameter int WIDTH     = 8,
  parameter int NREQ      = 4,
  parameter int MAX_BURST = 4,
  parameter int CNT_W     = 16
) (
  input  logic                      wr_clk,
  input  logic                      rstn,
  input  logic [NREQ-1:0]           req_valid,
  input  logic [NREQ*WIDTH-1:0]     req_data,
  output logic [NREQ-1:0]           req_ready,
  input  logic                      fifo_full,
  input  logic                      fifo_almost_full,
  output logic                      fifo_wr_en,
  output logic [WIDTH-1:0]          fifo_wr_data,
  output logic [$clog2(NREQ)-1:0]   grant_id,
  output logic                      busy,
  output logic [CNT_W-1:0]          word_count
);

  localparam int GW = $clog2(NREQ);
  localparam int BW = $clog2(MAX_BURST + 1);

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_e;

  state_e           state_q;
  logic             busy_q;
  logic [GW-1:0]    grant_q;
  logic [GW-1:0]    ptr_q;
  logic [BW-1:0]    beat_q;
  logic [CNT_W-1:0] count_q;

  logic [GW-1:0]    winner_d;
  logic [GW-1:0]    idx_s;
  logic             found_s;
  logic             can_grant_s;
  logic             grant_valid_s;
  logic             accept_s;
  logic             last_beat_s;

  // Round-robin search: first valid requester strictly after the pointer.
  always_comb begin
    winner_d = '0;
    idx_s    = '0;
    found_s  = 1'b0;
    for (int k = 1; k <= NREQ; k++) begin
      idx_s = GW'((int'(ptr_q) + k) % NREQ);
      if (!found_s && req_valid[idx_s]) begin
        found_s  = 1'b1;
        winner_d = idx_s;
      end else begin
        found_s  = found_s;
      end
    end
    can_grant_s = (|req_valid) && !fifo_full && !fifo_almost_full;
  end

  // Write-port steering is combinational so an accepted word reaches the FIFO the same cycle.
  always_comb begin
    grant_valid_s = req_valid[grant_q];
    accept_s      = (state_q == BURST) && grant_valid_s && !fifo_full;
    last_beat_s   = (beat_q == BW'(MAX_BURST - 1));
    fifo_wr_en    = accept_s;
    fifo_wr_data  = '0;
    req_ready     = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant_q == GW'(i)) begin
        fifo_wr_data = req_data[i*WIDTH +: WIDTH];
        req_ready[i] = (state_q == BURST) && !fifo_full;
      end else begin
        req_ready[i] = 1'b0;
      end
    end
  end

  // Grant/burst state machine; ptr starts at NREQ-1 so requester 0 wins first.
  always_ff @(posedge wr_clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      busy_q  <= 1'b0;
      grant_q <= '0;
      ptr_q   <= GW'(NREQ - 1);
      beat_q  <= '0;
      count_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (can_grant_s) begin
            state_q <= BURST;
            busy_q  <= 1'b1;
            grant_q <= winner_d;
            ptr_q   <= winner_d;
            beat_q  <= '0;
          end else begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        end
        BURST: begin
          if (accept_s) begin
            beat_q <= beat_q + BW'(1);
            if (count_q != {CNT_W{1'b1}}) begin
              count_q <= count_q + CNT_W'(1);
            end else begin
              count_q <= count_q;
            end
          end else begin
            beat_q <= beat_q;
          end
          // A dropped valid ends the burst; the pointer already sits on this requester.
          if ((accept_s && last_beat_s) || !grant_valid_s) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end else begin
            state_q <= BURST;
            busy_q  <= 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign grant_id   = grant_q;
  assign busy       = busy_q;
  assign word_count = count_q;

endmodule
